// File: rtl/fence_sequencer.sv
// Fence sequencer: drains the store buffer, then issues D$/I$/TLB flushes in a fixed order and pulses done_o.
// Optional FENCE_SEQ_PERF_EN adds stall_cycles_o, a free-running count of busy cycles.
module fence_sequencer #(
  parameter int unsigned DRAIN_TIMEOUT    = 1024,
  parameter int unsigned TLB_FLUSH_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_valid_i,
  input  logic [1:0] req_type_i,
  output logic       req_ready_o,
  input  logic       kill_i,
  input  logic       no_st_pending_i,
  output logic       flush_dcache_o,
  input  logic       flush_dcache_ack_i,
  output logic       flush_icache_o,
  output logic       flush_tlb_o,
  output logic       done_o,
  output logic       timeout_o,
  output logic       busy_o
`ifdef FENCE_SEQ_PERF_EN
  ,
  output logic [31:0] stall_cycles_o
`endif
);

  localparam int unsigned DCW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int unsigned TCW = (TLB_FLUSH_CYCLES > 1) ? $clog2(TLB_FLUSH_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_MAX = DCW'(DRAIN_TIMEOUT);
  localparam logic [TCW-1:0] TLB_LAST  = TCW'(TLB_FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, DRAIN, FLUSH_D, FLUSH_I, FLUSH_TLB, DONE
  } state_e;

  typedef enum logic [1:0] {
    T_FENCE, T_FENCE_I, T_SFENCE_VMA, T_FENCE_T
  } fence_type_e;

  state_e          state_q, state_d;
  fence_type_e     type_q, type_d;
  logic [DCW-1:0]  drainCnt_q, drainCnt_d;
  logic [TCW-1:0]  tlbCnt_q, tlbCnt_d;
  logic            killed_q, killed_d;

  state_e afterDrain, afterDcache, afterIcache;

  assign afterDrain  = (type_q == T_SFENCE_VMA) ? FLUSH_TLB : FLUSH_D;
  assign afterDcache = (type_q == T_FENCE_I || type_q == T_FENCE_T) ? FLUSH_I : DONE;
  assign afterIcache = (type_q == T_FENCE_T) ? FLUSH_TLB : DONE;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      type_q     <= T_FENCE;
      drainCnt_q <= '0;
      tlbCnt_q   <= '0;
      killed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      drainCnt_q <= drainCnt_d;
      tlbCnt_q   <= tlbCnt_d;
      killed_q   <= killed_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    drainCnt_d = drainCnt_q;
    tlbCnt_d   = '0;
    killed_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i && !kill_i) begin
          state_d    = DRAIN;
          type_d     = fence_type_e'(req_type_i);
          drainCnt_d = '0;
        end
      end
      DRAIN: begin
        if (kill_i) begin
          state_d = IDLE;
        end else if (no_st_pending_i) begin
          state_d = afterDrain;
        end else if (drainCnt_q != DRAIN_MAX) begin
          drainCnt_d = drainCnt_q + 1'b1;
        end
      end
      // A started cache flush always runs to its ack; a kill only suppresses what follows.
      FLUSH_D: begin
        killed_d = killed_q | kill_i;
        if (flush_dcache_ack_i) begin
          state_d  = killed_d ? IDLE : afterDcache;
          killed_d = 1'b0;
        end
      end
      FLUSH_I: begin
        state_d = kill_i ? IDLE : afterIcache;
      end
      FLUSH_TLB: begin
        if (kill_i) begin
          state_d = IDLE;
        end else if (tlbCnt_q == TLB_LAST) begin
          state_d = DONE;
        end else begin
          tlbCnt_d = tlbCnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready_o    = (state_q == IDLE);
  assign busy_o         = (state_q != IDLE);
  assign flush_dcache_o = (state_q == FLUSH_D);
  assign flush_icache_o = (state_q == FLUSH_I);
  assign flush_tlb_o    = (state_q == FLUSH_TLB) && (tlbCnt_q == '0);
  assign done_o         = (state_q == DONE);
  assign timeout_o      = (state_q == DRAIN) && (drainCnt_q == DRAIN_MAX);

`ifdef FENCE_SEQ_PERF_EN
  logic [31:0] stallCnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stallCnt_q <= '0;
    end else if (busy_o) begin
      stallCnt_q <= stallCnt_q + 32'd1;
    end
  end

  assign stall_cycles_o = stallCnt_q;
`endif

endmodule

// File: tb/tb_fence_sequencer.sv
// Directed bench for fence_sequencer: cycle-by-cycle vector table plus a FENCE_T full-run sequence.
// Build with FENCE_SEQ_PERF_EN defined to also check stall_cycles_o.
module tb_fence_sequencer;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       reqValid = 1'b0;
  logic [1:0] reqType = 2'd0;
  logic       reqReady;
  logic       kill = 1'b0;
  logic       noStPending = 1'b0;
  logic       flushD;
  logic       flushDAck = 1'b0;
  logic       flushI;
  logic       flushTlb;
  logic       done;
  logic       timeout;
  logic       busy;
`ifdef FENCE_SEQ_PERF_EN
  logic [31:0] stallCycles;
`endif

  int testsRun = 0;
  int testsFailed = 0;
  int expStall = 0;

  always #5 clk = ~clk;

  fence_sequencer #(
    .DRAIN_TIMEOUT(4),
    .TLB_FLUSH_CYCLES(2)
  ) dut (
    .clk_i(clk),
    .rst_ni(rstN),
    .req_valid_i(reqValid),
    .req_type_i(reqType),
    .req_ready_o(reqReady),
    .kill_i(kill),
    .no_st_pending_i(noStPending),
    .flush_dcache_o(flushD),
    .flush_dcache_ack_i(flushDAck),
    .flush_icache_o(flushI),
    .flush_tlb_o(flushTlb),
    .done_o(done),
    .timeout_o(timeout),
    .busy_o(busy)
`ifdef FENCE_SEQ_PERF_EN
    ,
    .stall_cycles_o(stallCycles)
`endif
  );

  // Expected output bundle: {ready, flushD, flushI, flushTlb, done, timeout, busy}
  localparam logic [6:0] O_IDLE  = 7'b1000000;
  localparam logic [6:0] O_DRAIN = 7'b0000001;
  localparam logic [6:0] O_DRTMO = 7'b0000011;
  localparam logic [6:0] O_FD    = 7'b0100001;
  localparam logic [6:0] O_FI    = 7'b0010001;
  localparam logic [6:0] O_TLB1  = 7'b0001001;
  localparam logic [6:0] O_TLBN  = 7'b0000001;
  localparam logic [6:0] O_DONE  = 7'b0000101;

  typedef struct {
    string      name;
    logic       rstN;
    logic       valid;
    logic [1:0] typ;
    logic       kill;
    logic       noSt;
    logic       ack;
    logic [6:0] expOut;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(string name, logic r, logic v, logic [1:0] t,
                                 logic k, logic ns, logic a, logic [6:0] e);
    vec_t x;
    x.name = name; x.rstN = r; x.valid = v; x.typ = t;
    x.kill = k; x.noSt = ns; x.ack = a; x.expOut = e;
    vecs.push_back(x);
  endfunction

  task automatic applyStimulus(input vec_t v);
    rstN        = v.rstN;
    reqValid    = v.valid;
    reqType     = v.typ;
    kill        = v.kill;
    noStPending = v.noSt;
    flushDAck   = v.ack;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [6:0] outBundle();
    return {reqReady, flushD, flushI, flushTlb, done, timeout, busy};
  endfunction

  initial begin
    int iCyc, tlbCyc, doneCyc, iCount, tlbCount;

    // Reset and FENCE_I with ack arriving on the 4th FLUSH_D cycle
    addVec("reset",        0, 0, 2'd0, 0, 0, 0, O_IDLE);
    addVec("fi.accept",    1, 1, 2'd1, 0, 1, 0, O_IDLE);
    addVec("fi.drain",     1, 1, 2'd1, 0, 1, 0, O_DRAIN);
    addVec("fi.fd1",       1, 1, 2'd1, 0, 1, 0, O_FD);
    addVec("fi.fd2",       1, 1, 2'd1, 0, 1, 0, O_FD);
    addVec("fi.fd3",       1, 1, 2'd1, 0, 1, 0, O_FD);
    addVec("fi.fd4ack",    1, 1, 2'd1, 0, 1, 1, O_FD);
    addVec("fi.icache",    1, 1, 2'd1, 0, 1, 0, O_FI);
    addVec("fi.done",      1, 1, 2'd1, 0, 1, 0, O_DONE);
    addVec("fi.idle",      1, 0, 2'd1, 0, 1, 0, O_IDLE);
    // SFENCE_VMA, five DRAIN cycles (the 5th reaches the timeout count)
    addVec("sf.accept",    1, 1, 2'd2, 0, 0, 0, O_IDLE);
    addVec("sf.drain1",    1, 1, 2'd2, 0, 0, 0, O_DRAIN);
    addVec("sf.drain2",    1, 1, 2'd2, 0, 0, 0, O_DRAIN);
    addVec("sf.drain3",    1, 1, 2'd2, 0, 0, 0, O_DRAIN);
    addVec("sf.drain4",    1, 1, 2'd2, 0, 0, 0, O_DRAIN);
    addVec("sf.drain5",    1, 1, 2'd2, 0, 1, 0, O_DRTMO);
    addVec("sf.tlb1",      1, 1, 2'd2, 0, 1, 0, O_TLB1);
    addVec("sf.tlb2",      1, 1, 2'd2, 0, 1, 0, O_TLBN);
    addVec("sf.done",      1, 1, 2'd2, 0, 1, 0, O_DONE);
    addVec("sf.idle",      1, 0, 2'd2, 0, 1, 0, O_IDLE);
    // FENCE with a long drain: timeout saturates, then drops when drained
    addVec("fe.accept",    1, 1, 2'd0, 0, 0, 0, O_IDLE);
    for (int i = 1; i <= 4; i++) addVec("fe.drain", 1, 1, 2'd0, 0, 0, 0, O_DRAIN);
    for (int i = 5; i <= 9; i++) addVec("fe.drainTmo", 1, 1, 2'd0, 0, 0, 0, O_DRTMO);
    addVec("fe.drained",   1, 1, 2'd0, 0, 1, 0, O_DRTMO);
    addVec("fe.fdack",     1, 1, 2'd0, 0, 1, 1, O_FD);
    addVec("fe.done",      1, 1, 2'd0, 0, 1, 0, O_DONE);
    addVec("fe.idle",      1, 0, 2'd0, 0, 1, 0, O_IDLE);
    // FENCE_T killed inside FLUSH_D: wait for ack, then straight to IDLE
    addVec("ft.accept",    1, 1, 2'd3, 0, 1, 0, O_IDLE);
    addVec("ft.drain",     1, 1, 2'd3, 0, 1, 0, O_DRAIN);
    addVec("ft.fd1",       1, 1, 2'd3, 0, 1, 0, O_FD);
    addVec("ft.fd2kill",   1, 0, 2'd3, 1, 1, 0, O_FD);
    for (int i = 0; i < 4; i++) addVec("ft.fdHold", 1, 0, 2'd3, 0, 1, 0, O_FD);
    addVec("ft.fdack",     1, 0, 2'd3, 0, 1, 1, O_FD);
    addVec("ft.idle1",     1, 0, 2'd3, 0, 1, 0, O_IDLE);
    addVec("ft.idle2",     1, 0, 2'd3, 0, 1, 0, O_IDLE);
    // Synchronous reset while in FLUSH_D, then a late ack
    addVec("rs.accept",    1, 1, 2'd0, 0, 1, 0, O_IDLE);
    addVec("rs.drain",     1, 1, 2'd0, 0, 1, 0, O_DRAIN);
    addVec("rs.fdReset",   0, 0, 2'd0, 0, 1, 0, O_FD);
    addVec("rs.lateAck",   1, 0, 2'd0, 0, 1, 1, O_IDLE);
    addVec("rs.idle",      1, 0, 2'd0, 0, 1, 0, O_IDLE);
    // Kill in IDLE blocks accept; kill in DRAIN aborts
    addVec("kl.idleKill",  1, 1, 2'd2, 1, 0, 0, O_IDLE);
    addVec("kl.accept",    1, 1, 2'd2, 0, 0, 0, O_IDLE);
    addVec("kl.drainKill", 1, 0, 2'd2, 1, 0, 0, O_DRAIN);
    addVec("kl.idle",      1, 0, 2'd2, 0, 0, 0, O_IDLE);
    // Kill on the TLB pulse cycle: pulse stands, no done
    addVec("kt.accept",    1, 1, 2'd2, 0, 1, 0, O_IDLE);
    addVec("kt.drain",     1, 1, 2'd2, 0, 1, 0, O_DRAIN);
    addVec("kt.tlbKill",   1, 0, 2'd2, 1, 1, 0, O_TLB1);
    addVec("kt.idle",      1, 0, 2'd2, 0, 1, 0, O_IDLE);
    // Kill on the I$ pulse cycle, then kill during DONE is ignored
    addVec("ki.accept",    1, 1, 2'd1, 0, 1, 0, O_IDLE);
    addVec("ki.drain",     1, 1, 2'd1, 0, 1, 0, O_DRAIN);
    addVec("ki.fdack",     1, 1, 2'd1, 0, 1, 1, O_FD);
    addVec("ki.icKill",    1, 0, 2'd1, 1, 1, 0, O_FI);
    addVec("ki.idle",      1, 0, 2'd1, 0, 1, 0, O_IDLE);
    addVec("kd.accept",    1, 1, 2'd0, 0, 1, 0, O_IDLE);
    addVec("kd.drain",     1, 1, 2'd0, 0, 1, 0, O_DRAIN);
    addVec("kd.fdack",     1, 1, 2'd0, 0, 1, 1, O_FD);
    addVec("kd.doneKill",  1, 0, 2'd0, 1, 1, 0, O_DONE);
    addVec("kd.idle",      1, 0, 2'd0, 0, 1, 0, O_IDLE);

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i].name, 32'(outBundle()), 32'(vecs[i].expOut));
`ifdef FENCE_SEQ_PERF_EN
      checkOutput({vecs[i].name, ".stall"}, stallCycles, 32'(expStall));
`endif
      if (!vecs[i].rstN) expStall = 0;
      else if (vecs[i].expOut[0]) expStall++;
    end

    // FENCE_T full run with an ack responder: D$, I$, TLB in order, then done
    @(negedge clk);
    rstN = 1'b1; kill = 1'b0; noStPending = 1'b1; flushDAck = 1'b0;
    reqValid = 1'b1; reqType = 2'd3;
    iCyc = -1; tlbCyc = -1; doneCyc = -1; iCount = 0; tlbCount = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      flushDAck = flushD;
      if (flushI) begin iCount++; iCyc = cyc; end
      if (flushTlb) begin tlbCount++; tlbCyc = cyc; end
      if (busy) expStall++;
      if (done) begin doneCyc = cyc; break; end
    end
    reqValid = 1'b0; flushDAck = 1'b0;
    checkOutput("ftRun.doneCycle", 32'(doneCyc), 32'd5);
    checkOutput("ftRun.icacheCount", 32'(iCount), 32'd1);
    checkOutput("ftRun.tlbCount", 32'(tlbCount), 32'd1);
    checkOutput("ftRun.icacheCycle", 32'(iCyc), 32'd2);
    checkOutput("ftRun.tlbCycle", 32'(tlbCyc), 32'd3);
    @(negedge clk);
    checkOutput("ftRun.idle", 32'(outBundle()), 32'(O_IDLE));
`ifdef FENCE_SEQ_PERF_EN
    checkOutput("ftRun.stall", stallCycles, 32'(expStall));
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
